// File: rtl/stream_src_sel.sv
// stream_src_sel
// Runtime-selectable sample source for the Sclk-domain stream into AXI2S Sin/Ien.
// Four sources: external samples, delayed Sout loopback, I/Q counter pattern and
// PRBS-15. Any mode change passes through a 2-cycle FLUSH that clears the
// pattern generators and the loopback valid bits before RUN resumes.
//
// Ports:
//   clk      in   stream clock (Sclk)
//   rst_n    in   asynchronous active-low reset
//   mode     in   2   0 EXT, 1 LOOP, 2 CNT, 3 PRBS (quasi-static)
//   loop_dly in   DLY_AW  loopback delay select (output lags by loop_dly+2 cycles)
//   sync     in   restart pulse for the CNT/PRBS sequences
//   ext_in   in   DW  external sample word, qualified by ext_vld
//   sout     in   DW  AXI2S Sout word, qualified by oen
//   ien      in   pattern advance request for CNT/PRBS
//   sin      out  DW  sample word to AXI2S Sin
//   sin_vld  out  sin valid
//   busy     out  high while flushing
// Word layout: channel c occupies [2*W*c +: 2*W], I in the low half, Q in the high half.

module stream_src_sel #(
    parameter int W      = 16,
    parameter int NCH    = 1,
    parameter int DLY_AW = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [DLY_AW-1:0]     loop_dly,
    input  logic                  sync,
    input  logic [2*W*NCH-1:0]    ext_in,
    input  logic                  ext_vld,
    input  logic [2*W*NCH-1:0]    sout,
    input  logic                  oen,
    input  logic                  ien,
    output logic [2*W*NCH-1:0]    sin,
    output logic                  sin_vld,
    output logic                  busy
);

    localparam int DW    = 2 * W * NCH;
    localparam int DEPTH = 1 << DLY_AW;

    localparam logic [1:0] MODE_EXT  = 2'd0;
    localparam logic [1:0] MODE_LOOP = 2'd1;
    localparam logic [1:0] MODE_CNT  = 2'd2;
    localparam logic [1:0] MODE_PRBS = 2'd3;

    localparam logic [14:0]       LFSR_SEED = 15'h7FFF;
    localparam logic [DLY_AW-1:0] PTR_ONE   = {{(DLY_AW-1){1'b0}}, 1'b1};

    typedef enum logic {
        FLUSH,
        RUN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                flush_cnt;
    logic [1:0]          mode_q;
    logic                mode_chg;

    logic [W-1:0]        cnt;
    logic [14:0]         lfsr;
    logic [14:0]         lfsr_nxt;
    logic [W-1:0]        prbs_i;

    logic [DW-1:0]       mem_dat [DEPTH];
    logic [DEPTH-1:0]    mem_vld;
    logic [DLY_AW-1:0]   wr_ptr;
    logic [DLY_AW-1:0]   rd_ptr;

    logic [DW-1:0]       cnt_word;
    logic [DW-1:0]       prbs_word;

    // A mode change is only acted on from RUN; while flushing the input mode is
    // simply re-latched so the flush always ends in the most recent mode.
    assign mode_chg = (state == RUN) && (mode != mode_q);

    // Reading wr_ptr-loop_dly-1 returns the entry written loop_dly+1 edges ago;
    // the output register adds one more cycle.
    assign rd_ptr = wr_ptr - loop_dly - PTR_ONE;

    // Fibonacci x^15+x^14+1: feedback from taps 15 and 14 (bits 14 and 13).
    assign lfsr_nxt = {lfsr[13:0], lfsr[14] ^ lfsr[13]};

    generate
        if (W >= 15) begin : g_prbs_ext
            assign prbs_i = {{(W-15){1'b0}}, lfsr};
        end else begin : g_prbs_trunc
            assign prbs_i = lfsr[W-1:0];
        end
    endgenerate

    // State register: FLUSH is held for exactly two cycles, counted by flush_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FLUSH;
            flush_cnt <= 1'b0;
            mode_q    <= MODE_EXT;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
            if (state == FLUSH || mode_chg) begin
                mode_q <= mode;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            FLUSH:   if (flush_cnt) state_nxt = RUN;
            RUN:     if (mode_chg)  state_nxt = FLUSH;
            default: state_nxt = FLUSH;
        endcase
    end

    // Output decode plus the per-channel pattern words for CNT and PRBS.
    always_comb begin
        busy      = (state == FLUSH);
        cnt_word  = '0;
        prbs_word = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_word[2*W*c +: W]      = ~cnt;
            cnt_word[2*W*c + W +: W]  = cnt + W'(c);
            prbs_word[2*W*c +: W]     = prbs_i ^ W'(c);
            prbs_word[2*W*c + W +: W] = ~(prbs_i ^ W'(c));
        end
    end

    // Datapath: output register, pattern generators and loopback bookkeeping.
    // Pattern outputs use the pre-advance value; sync takes priority over ien
    // for the next value so the following output restarts the sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin     <= '0;
            sin_vld <= 1'b0;
            cnt     <= '0;
            lfsr    <= LFSR_SEED;
            wr_ptr  <= '0;
            mem_vld <= '0;
        end else if (state == FLUSH) begin
            sin_vld <= 1'b0;
            cnt     <= '0;
            lfsr    <= LFSR_SEED;
            wr_ptr  <= '0;
            mem_vld <= '0;
        end else begin
            wr_ptr          <= wr_ptr + PTR_ONE;
            mem_vld[wr_ptr] <= oen;
            if (mode_chg) begin
                sin_vld <= 1'b0;
            end else begin
                case (mode_q)
                    MODE_EXT: begin
                        sin     <= ext_in;
                        sin_vld <= ext_vld;
                    end
                    MODE_LOOP: begin
                        sin     <= mem_dat[rd_ptr];
                        sin_vld <= mem_vld[rd_ptr];
                    end
                    MODE_CNT: begin
                        sin     <= cnt_word;
                        sin_vld <= ien;
                        if (sync)     cnt <= '0;
                        else if (ien) cnt <= cnt + 1'b1;
                    end
                    default: begin
                        sin     <= prbs_word;
                        sin_vld <= ien;
                        if (sync)     lfsr <= LFSR_SEED;
                        else if (ien) lfsr <= lfsr_nxt;
                    end
                endcase
            end
        end
    end

    // Loopback data storage; validity lives in mem_vld, so no reset is needed.
    always_ff @(posedge clk) begin
        if (state == RUN) begin
            mem_dat[wr_ptr] <= sout;
        end
    end

endmodule

// File: tb/tb_stream_src_sel.sv
// tb_stream_src_sel
// Directed bench for stream_src_sel with W=16, NCH=2, DLY_AW=4. Expected words
// are queued when stimulus is issued; a monitor pops one entry per valid output.
// Cycle-exact checks on busy/sin_vld are made directly from the stimulus process.

module tb_stream_src_sel;

    localparam int W      = 16;
    localparam int NCH    = 2;
    localparam int DLY_AW = 4;
    localparam int DW     = 2 * W * NCH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic [DLY_AW-1:0] loop_dly;
    logic              sync;
    logic [DW-1:0]     ext_in;
    logic              ext_vld;
    logic [DW-1:0]     sout;
    logic              oen;
    logic              ien;
    logic [DW-1:0]     sin;
    logic              sin_vld;
    logic              busy;

    typedef struct {
        logic [DW-1:0] word;
        bit            chk;
        int            tag;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        n_vec = 0;
    int        n_bad = 0;

    stream_src_sel #(.W(W), .NCH(NCH), .DLY_AW(DLY_AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .loop_dly (loop_dly),
        .sync     (sync),
        .ext_in   (ext_in),
        .ext_vld  (ext_vld),
        .sout     (sout),
        .oen      (oen),
        .ien      (ien),
        .sin      (sin),
        .sin_vld  (sin_vld),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Counter pattern word for count n: I = ~n, Q = n + channel.
    function automatic logic [DW-1:0] cnt_word(input int n);
        logic [W-1:0] v;
        cnt_word = '0;
        v = W'(n);
        for (int c = 0; c < NCH; c++) begin
            cnt_word[2*W*c +: W]     = ~v;
            cnt_word[2*W*c + W +: W] = v + W'(c);
        end
    endfunction

    task automatic push(input logic [DW-1:0] word, input bit chk, input int tag);
        sb_entry_t e;
        e.word = word;
        e.chk  = chk;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [DW-1:0] actual,
                                input logic [DW-1:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one oen pulse and check sin_vld is high on exactly the (d+1)th edge
    // after the write edge, then idle long enough for the entry to be overwritten.
    task automatic apply_stimulus_loop(input logic [DLY_AW-1:0] d, input logic [DW-1:0] word);
        loop_dly = d;
        oen      = 1'b1;
        sout     = word;
        push(word, 1'b1, 300 + int'(d));
        tick();
        oen  = 1'b0;
        sout = '0;
        for (int k = 1; k <= int'(d) + 2; k++) begin
            tick();
            check_output($sformatf("loop_d%0d_vld_k%0d", d, k), DW'(sin_vld),
                         DW'(k == int'(d) + 1));
        end
        repeat (16) tick();
    endtask

    // Scoreboard monitor: every valid output must match the oldest queued entry.
    always @(negedge clk) begin
        if (rst_n && sin_vld) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("[TB] FAIL unexpected_vld: got %h, expected no valid output", sin);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                if (e.chk) begin
                    n_vec++;
                    if (sin !== e.word) begin
                        n_bad++;
                        $display("[TB] FAIL sb_tag%0d: got %h, expected %h", e.tag, sin, e.word);
                    end
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        mode     = 2'd2;
        loop_dly = '0;
        sync     = 1'b0;
        ext_in   = '0;
        ext_vld  = 1'b0;
        sout     = '0;
        oen      = 1'b0;
        ien      = 1'b1;

        // Reset state, CNT start-up and first-word latency.
        tick();
        tick();
        check_output("rst_sin", sin, '0);
        check_output("rst_vld", DW'(sin_vld), '0);
        check_output("rst_busy", DW'(busy), DW'(1));
        rst_n = 1'b1;
        tick();
        check_output("flush1_busy", DW'(busy), DW'(1));
        check_output("flush1_vld", DW'(sin_vld), '0);
        tick();
        check_output("run_busy", DW'(busy), '0);
        check_output("run_vld", DW'(sin_vld), '0);
        push(64'h0001FFFF_0000FFFF, 1'b1, 0);
        push(64'h0002FFFE_0001FFFE, 1'b1, 1);
        for (int i = 2; i < 10; i++) push(cnt_word(i), 1'b1, i);
        tick();
        check_output("cnt_first_vld", DW'(sin_vld), DW'(1));
        repeat (9) tick();

        // Sync together with ien: shows count 10, then the sequence restarts.
        sync = 1'b1;
        push(cnt_word(10), 1'b1, 10);
        tick();
        sync = 1'b0;
        push(64'h0001FFFF_0000FFFF, 1'b1, 11);
        push(64'h0002FFFE_0001FFFE, 1'b1, 12);
        tick();
        tick();

        // CNT -> EXT while ien stays high.
        mode = 2'd0;
        tick();
        check_output("sw_ext_busy0", DW'(busy), DW'(1));
        check_output("sw_ext_vld0", DW'(sin_vld), '0);
        tick();
        check_output("sw_ext_busy1", DW'(busy), DW'(1));
        check_output("sw_ext_vld1", DW'(sin_vld), '0);
        tick();
        check_output("sw_ext_busy2", DW'(busy), '0);
        check_output("sw_ext_vld2", DW'(sin_vld), '0);
        ext_in  = 64'h1234_5678_9ABC_DEF0;
        ext_vld = 1'b1;
        push(ext_in, 1'b1, 100);
        tick();
        check_output("ext_lat1", sin, 64'h1234_5678_9ABC_DEF0);
        ext_in = 64'hFEDC_BA98_7654_3210;
        push(ext_in, 1'b1, 101);
        tick();
        ext_vld = 1'b0;
        ext_in  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        check_output("ext_novld", DW'(sin_vld), '0);
        ext_vld = 1'b1;
        ext_in  = 64'h0F0F_0F0F_F0F0_F0F0;
        push(ext_in, 1'b1, 102);
        tick();
        ext_vld = 1'b0;

        // EXT -> CNT restarts the counter at I = 0xFFFF.
        mode = 2'd2;
        repeat (3) tick();
        push(64'h0001FFFF_0000FFFF, 1'b1, 200);
        push(64'h0002FFFE_0001FFFE, 1'b1, 201);
        push(cnt_word(2), 1'b1, 202);
        repeat (3) tick();

        // PRBS: first three states by hand, then the period closes after 32767 steps.
        mode = 2'd3;
        repeat (3) tick();
        for (int i = 0; i <= 32768; i++) begin
            if (i == 0)                      push(64'h80017FFE_80007FFF, 1'b1, 400);
            else if (i == 1)                 push(64'h80007FFF_80017FFE, 1'b1, 401);
            else if (i == 2)                 push(64'h80027FFD_80037FFC, 1'b1, 402);
            else if (i == 32767)             push(64'h80017FFE_80007FFF, 1'b1, 403);
            else if (i == 32768)             push(64'h80007FFF_80017FFE, 1'b1, 404);
            else                             push('0, 1'b0, 0);
            tick();
        end
        ien = 1'b0;

        // LOOP: delay 3, then delay 15 repeated so the pointer wraps.
        mode     = 2'd1;
        loop_dly = 4'd3;
        repeat (3) tick();
        repeat (20) tick();
        apply_stimulus_loop(4'd3, {2{32'hA5A5_5A5A}});
        apply_stimulus_loop(4'd15, 64'h1111_2222_3333_4444);
        apply_stimulus_loop(4'd15, 64'h5555_6666_7777_8888);
        apply_stimulus_loop(4'd15, 64'h9999_AAAA_BBBB_CCCC);

        // Asynchronous reset with entries still in the delay line.
        loop_dly = 4'd7;
        for (int i = 0; i < 5; i++) begin
            oen  = 1'b1;
            sout = DW'(64'hC0DE_0000_0000_0000) + DW'(i);
            tick();
        end
        oen  = 1'b0;
        sout = '0;
        repeat (4) tick();
        check_output("pre_rst_vld", DW'(sin_vld), DW'(1));
        check_output("pre_rst_sin", sin, 64'hC0DE_0000_0000_0000);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_vld", DW'(sin_vld), '0);
        check_output("async_rst_sin", sin, '0);
        check_output("async_rst_busy", DW'(busy), DW'(1));
        #10;
        rst_n = 1'b1;
        repeat (30) tick();
        check_output("post_rst_busy", DW'(busy), '0);
        check_output("post_rst_vld", DW'(sin_vld), '0);

        check_output("sb_leftover", DW'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
